// File: rtl/alu_pkg.sv
// Shared ALU definitions: condition-code encodings and status-flag bit positions.
package alu_pkg;
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_LTS = 4'h2;
   localparam logic [3:0] COND_GES = 4'h3;
   localparam logic [3:0] COND_LTU = 4'h4;
   localparam logic [3:0] COND_GEU = 4'h5;
   localparam logic [3:0] COND_GTS = 4'h6;
   localparam logic [3:0] COND_LES = 4'h7;
   localparam logic [3:0] COND_GTU = 4'h8;
   localparam logic [3:0] COND_LEU = 4'h9;
   localparam logic [3:0] COND_VS = 4'hA;
   localparam logic [3:0] COND_VC = 4'hB;
   localparam logic [3:0] COND_MI = 4'hC;
   localparam logic [3:0] COND_PL = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_V = 1;
   localparam int FLG_B = 0;
endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator: {N,Z,V,B} flags and a 4-bit condition -> taken.
// Purely combinational, no latency, no flow control.
module cond_eval
   import alu_pkg::*;
(
   input  logic [3:0] i_flags,
   input  logic [3:0] i_cond,
   output logic       o_taken
);
   logic w_n, w_z, w_v, w_b, w_s;

   assign w_n = i_flags[FLG_N];
   assign w_z = i_flags[FLG_Z];
   assign w_v = i_flags[FLG_V];
   assign w_b = i_flags[FLG_B];
   // signed less-than after a subtract is N xor V
   assign w_s = w_n ^ w_v;

   always_comb begin
      o_taken = 1'b0;
      case (i_cond)
         COND_EQ:  o_taken = w_z;
         COND_NE:  o_taken = ~w_z;
         COND_LTS: o_taken = w_s;
         COND_GES: o_taken = ~w_s;
         COND_LTU: o_taken = w_b;
         COND_GEU: o_taken = ~w_b;
         COND_GTS: o_taken = ~w_z & ~w_s;
         COND_LES: o_taken = w_z | w_s;
         COND_GTU: o_taken = ~w_b & ~w_z;
         COND_LEU: o_taken = w_b | w_z;
         COND_VS:  o_taken = w_v;
         COND_VC:  o_taken = ~w_v;
         COND_MI:  o_taken = w_n;
         COND_PL:  o_taken = ~w_n;
         COND_AL:  o_taken = 1'b1;
         default:  o_taken = 1'b0;
      endcase
   end
endmodule

// File: rtl/flag_cond_unit.sv
// Flag status register plus condition-query responder; response 1 cycle after accept.
// Single output register: q_ready = ~r_valid | r_ready, r_* held while stalled.
module flag_cond_unit
   import alu_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flags_we,
   input  logic             ZeroFlag,
   input  logic             NegativeFlag,
   input  logic             OverflowFlag,
   input  logic             BorrowFlag,
   input  logic             q_valid,
   output logic             q_ready,
   input  logic [3:0]       q_cond,
   input  logic [TAG_W-1:0] q_tag,
   output logic             r_valid,
   input  logic             r_ready,
   output logic             r_taken,
   output logic             r_err,
   output logic [TAG_W-1:0] r_tag,
   output logic [3:0]       flags_q,
   output logic             sticky_v,
   input  logic             sticky_clr,
   output logic [CNT_W-1:0] taken_cnt
);
   logic       r_flags_vld;
   logic [3:0] w_flags_in;
   logic [3:0] w_flags_eff;
   logic       w_flags_ok;
   logic       w_accept;
   logic       w_eval;
   logic       w_taken;

   assign w_flags_in  = {NegativeFlag, ZeroFlag, OverflowFlag, BorrowFlag};
   // same-cycle flag write bypasses the status register
   assign w_flags_eff = flags_we ? w_flags_in : flags_q;
   assign w_flags_ok  = flags_we | r_flags_vld;
   assign q_ready     = ~r_valid | r_ready;
   assign w_accept    = q_valid & q_ready;
   assign w_taken     = w_flags_ok & w_eval;

   cond_eval u_cond_eval (
      .i_flags (w_flags_eff),
      .i_cond  (q_cond),
      .o_taken (w_eval)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_flags_vld <= 1'b0;
         flags_q     <= 4'b0000;
         sticky_v    <= 1'b0;
      end else begin
         if (flags_we) begin
            flags_q     <= w_flags_in;
            r_flags_vld <= 1'b1;
         end
         if (flags_we & OverflowFlag) begin
            sticky_v <= 1'b1;
         end else if (sticky_clr) begin
            sticky_v <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_taken   <= 1'b0;
         r_err     <= 1'b0;
         r_tag     <= '0;
         taken_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_valid <= 1'b1;
            r_taken <= w_taken;
            r_err   <= ~w_flags_ok;
            r_tag   <= q_tag;
         end else if (r_ready) begin
            r_valid <= 1'b0;
         end
         if (w_accept && w_taken && (taken_cnt != {CNT_W{1'b1}})) begin
            taken_cnt <= taken_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_flag_cond_unit.sv
// Bench for flag_cond_unit: directed scenarios plus a randomized run against an operand-level model.
module tb_flag_cond_unit;
   localparam int TAG_W = 4;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst, flags_we;
   logic             ZeroFlag, NegativeFlag, OverflowFlag, BorrowFlag;
   logic             q_valid, q_ready, r_valid, r_ready;
   logic [3:0]       q_cond;
   logic [TAG_W-1:0] q_tag, r_tag;
   logic             r_taken, r_err, sticky_v, sticky_clr;
   logic [3:0]       flags_q;
   logic [CNT_W-1:0] taken_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   flag_cond_unit #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flags_we(flags_we),
      .ZeroFlag(ZeroFlag), .NegativeFlag(NegativeFlag),
      .OverflowFlag(OverflowFlag), .BorrowFlag(BorrowFlag),
      .q_valid(q_valid), .q_ready(q_ready), .q_cond(q_cond), .q_tag(q_tag),
      .r_valid(r_valid), .r_ready(r_ready), .r_taken(r_taken), .r_err(r_err),
      .r_tag(r_tag), .flags_q(flags_q), .sticky_v(sticky_v),
      .sticky_clr(sticky_clr), .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      rst = 1'b0; flags_we = 1'b0; q_valid = 1'b0; r_ready = 1'b1;
      sticky_clr = 1'b0; q_cond = 4'h0; q_tag = '0;
      {NegativeFlag, ZeroFlag, OverflowFlag, BorrowFlag} = 4'b0000;
   endtask

   // {N,Z,V,B} that an 8-bit subtractor reports for a-b
   function automatic logic [3:0] ops_flags(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] d;
      d = a - b;
      return {d[7], a == b, (a[7] != b[7]) && (d[7] != a[7]), a < b};
   endfunction

   // Condition result straight from the operand relation
   function automatic logic exp_taken(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
      logic [3:0] f;
      f = ops_flags(a, b);
      case (c)
         4'h0: return a == b;
         4'h1: return a != b;
         4'h2: return $signed(a) < $signed(b);
         4'h3: return $signed(a) >= $signed(b);
         4'h4: return a < b;
         4'h5: return a >= b;
         4'h6: return $signed(a) > $signed(b);
         4'h7: return $signed(a) <= $signed(b);
         4'h8: return a > b;
         4'h9: return a <= b;
         4'hA: return f[1];
         4'hB: return !f[1];
         4'hC: return f[3];
         4'hD: return !f[3];
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
      {NegativeFlag, ZeroFlag, OverflowFlag, BorrowFlag} = ops_flags(a, b);
      flags_we = 1'b1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs;
      rst = 1'b1;
      tick;
      tick;
      n_cmp++;
      if ({r_valid, r_taken, r_err, r_tag, flags_q, sticky_v, taken_cnt} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got v=%b t=%b e=%b tag=%h f=%h sv=%b cnt=%0d, want all 0",
                  r_valid, r_taken, r_err, r_tag, flags_q, sticky_v, taken_cnt);
      end
      n_cmp++;
      if (q_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_q_ready: got %b want 1", q_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_err_no_flags;
      q_valid = 1'b1; q_cond = 4'h1; q_tag = 4'd5;
      tick;
      q_valid = 1'b0;
      n_cmp++;
      if ({r_valid, r_err, r_taken, r_tag} !== {1'b1, 1'b1, 1'b0, 4'd5}) begin
         n_bad++;
         $display("FAIL err_no_flags: got v=%b e=%b t=%b tag=%h want v=1 e=1 t=0 tag=5",
                  r_valid, r_err, r_taken, r_tag);
      end
      tick;
      n_cmp++;
      if (r_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL drain_after_ready: r_valid got %b want 0", r_valid);
      end
   endtask

   task automatic test_eq;
      load_ops(8'd7, 8'd7);
      tick;
      flags_we = 1'b0;
      n_cmp++;
      if (flags_q !== 4'b0100) begin
         n_bad++;
         $display("FAIL eq_flags_q: got %b want 0100", flags_q);
      end
      q_valid = 1'b1; q_cond = 4'h0; q_tag = 4'd3;
      tick;
      q_valid = 1'b0;
      n_cmp++;
      if ({r_valid, r_taken, r_err, r_tag} !== {1'b1, 1'b1, 1'b0, 4'd3}) begin
         n_bad++;
         $display("FAIL eq_response: got v=%b t=%b e=%b tag=%h want v=1 t=1 e=0 tag=3",
                  r_valid, r_taken, r_err, r_tag);
      end
      n_cmp++;
      if (taken_cnt !== 2'd1) begin
         n_bad++;
         $display("FAIL eq_taken_cnt: got %0d want 1", taken_cnt);
      end
      tick;
   endtask

   task automatic test_signed_unsigned;
      logic [3:0] conds [3];
      logic       want  [3];
      conds = '{4'h2, 4'h4, 4'h5};
      want  = '{1'b1, 1'b0, 1'b1};
      load_ops(8'hFF, 8'h01);
      tick;
      flags_we = 1'b0;
      n_cmp++;
      if (flags_q !== 4'b1000) begin
         n_bad++;
         $display("FAIL signed_flags_q: got %b want 1000", flags_q);
      end
      for (int i = 0; i < 3; i++) begin
         q_valid = 1'b1; q_cond = conds[i]; q_tag = 4'(i);
         tick;
         n_cmp++;
         if (r_valid !== 1'b1 || r_taken !== want[i] || r_tag !== 4'(i)) begin
            n_bad++;
            $display("FAIL signed_cond_%0h: got v=%b t=%b tag=%h want v=1 t=%b tag=%h",
                     conds[i], r_valid, r_taken, r_tag, want[i], 4'(i));
         end
      end
      q_valid = 1'b0;
      tick;
   endtask

   task automatic test_backpressure;
      r_ready = 1'b0;
      q_valid = 1'b1; q_cond = 4'hE; q_tag = 4'd9;
      tick;
      q_cond = 4'hF; q_tag = 4'd10;
      #1;
      n_cmp++;
      if (r_valid !== 1'b1 || r_tag !== 4'd9 || q_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_first: got v=%b tag=%h q_ready=%b want v=1 tag=9 q_ready=0",
                  r_valid, r_tag, q_ready);
      end
      for (int i = 0; i < 5; i++) begin
         tick;
         n_cmp++;
         if ({r_valid, r_taken, r_err, r_tag, q_ready} !== {1'b1, 1'b1, 1'b0, 4'd9, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_hold_%0d: got v=%b t=%b e=%b tag=%h rdy=%b want 1 1 0 9 0",
                     i, r_valid, r_taken, r_err, r_tag, q_ready);
         end
      end
      r_ready = 1'b1;
      #1;
      n_cmp++;
      if (q_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_release_ready: q_ready got %b want 1", q_ready);
      end
      tick;
      q_valid = 1'b0;
      n_cmp++;
      if ({r_valid, r_taken, r_tag} !== {1'b1, 1'b0, 4'd10}) begin
         n_bad++;
         $display("FAIL bp_second: got v=%b t=%b tag=%h want v=1 t=0 tag=a",
                  r_valid, r_taken, r_tag);
      end
      tick;
   endtask

   task automatic test_bypass;
      do_reset;
      load_ops(8'd3, 8'd5);
      q_valid = 1'b1; q_cond = 4'h1; q_tag = 4'd2;
      tick;
      q_valid = 1'b0; flags_we = 1'b0;
      n_cmp++;
      if ({r_valid, r_err, r_taken} !== 3'b101) begin
         n_bad++;
         $display("FAIL bypass_after_reset: got v=%b e=%b t=%b want v=1 e=0 t=1",
                  r_valid, r_err, r_taken);
      end
      load_ops(8'd4, 8'd4);
      tick;
      load_ops(8'd9, 8'd1);
      q_valid = 1'b1; q_cond = 4'h1; q_tag = 4'd6;
      tick;
      q_valid = 1'b0; flags_we = 1'b0;
      n_cmp++;
      if ({r_err, r_taken, r_tag} !== {1'b0, 1'b1, 4'd6}) begin
         n_bad++;
         $display("FAIL bypass_over_stale: got e=%b t=%b tag=%h want e=0 t=1 tag=6",
                  r_err, r_taken, r_tag);
      end
      tick;
   endtask

   task automatic test_sticky;
      load_ops(8'h80, 8'h01);
      sticky_clr = 1'b1;
      tick;
      flags_we = 1'b0;
      n_cmp++;
      if (sticky_v !== 1'b1) begin
         n_bad++;
         $display("FAIL sticky_set_wins: got %b want 1", sticky_v);
      end
      tick;
      sticky_clr = 1'b0;
      n_cmp++;
      if (sticky_v !== 1'b0) begin
         n_bad++;
         $display("FAIL sticky_clear: got %b want 0", sticky_v);
      end
   endtask

   task automatic test_saturation_and_reset;
      int want;
      do_reset;
      load_ops(8'd1, 8'd2);
      tick;
      flags_we = 1'b0;
      q_valid = 1'b1; q_cond = 4'hE;
      for (int i = 0; i < 6; i++) begin
         q_tag = 4'(i);
         tick;
         want = (i + 1 > 3) ? 3 : i + 1;
         n_cmp++;
         if (taken_cnt !== CNT_W'(want)) begin
            n_bad++;
            $display("FAIL sat_cnt_%0d: got %0d want %0d", i, taken_cnt, want);
         end
      end
      q_valid = 1'b0;
      r_ready = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      r_ready = 1'b1;
      n_cmp++;
      if (r_valid !== 1'b0 || taken_cnt !== '0) begin
         n_bad++;
         $display("FAIL mid_reset: got v=%b cnt=%0d want v=0 cnt=0", r_valid, taken_cnt);
      end
   endtask

   task automatic test_random;
      logic       m_vld, m_sticky, m_rv, m_rt, m_re, acc, ok, we, rr, clr, qv;
      logic [7:0] m_a, m_b, a, b, ea, eb;
      logic [3:0] cond, tag, m_tag, fl, want_f;
      int         m_cnt;
      idle_inputs;
      do_reset;
      m_vld = 0; m_sticky = 0; m_rv = 0; m_rt = 0; m_re = 0; m_tag = 0;
      m_a = 0; m_b = 0; m_cnt = 0;
      for (int n = 0; n < 400; n++) begin
         a = 8'($urandom);
         b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
         we = ($urandom_range(0, 2) == 0);
         qv = $urandom_range(0, 1);
         rr = ($urandom_range(0, 9) < 7);
         clr = ($urandom_range(0, 7) == 0);
         cond = 4'($urandom);
         tag = 4'($urandom);
         if (we) load_ops(a, b);
         else begin
            flags_we = 1'b0;
            {NegativeFlag, ZeroFlag, OverflowFlag, BorrowFlag} = 4'($urandom);
         end
         q_valid = qv; q_cond = cond; q_tag = tag; r_ready = rr; sticky_clr = clr;
         #1;
         n_cmp++;
         if (q_ready !== (!m_rv || rr)) begin
            n_bad++;
            $display("FAIL rnd_q_ready_%0d: got %b want %b", n, q_ready, !m_rv || rr);
         end
         acc = qv && (!m_rv || rr);
         tick;
         if (acc) begin
            ok = we || m_vld;
            ea = we ? a : m_a;
            eb = we ? b : m_b;
            m_rt = ok ? exp_taken(cond, ea, eb) : 1'b0;
            m_re = !ok;
            m_tag = tag;
            m_rv = 1'b1;
            if (m_rt && m_cnt < 3) m_cnt++;
         end else if (rr) begin
            m_rv = 1'b0;
         end
         fl = ops_flags(a, b);
         if (we) begin
            m_a = a; m_b = b; m_vld = 1'b1;
         end
         if (we && fl[1]) m_sticky = 1'b1;
         else if (clr) m_sticky = 1'b0;
         want_f = m_vld ? ops_flags(m_a, m_b) : 4'b0000;
         n_cmp++;
         if (r_valid !== m_rv || (m_rv && {r_taken, r_err, r_tag} !== {m_rt, m_re, m_tag})) begin
            n_bad++;
            $display("FAIL rnd_resp_%0d: got v=%b t=%b e=%b tag=%h want v=%b t=%b e=%b tag=%h",
                     n, r_valid, r_taken, r_err, r_tag, m_rv, m_rt, m_re, m_tag);
         end
         n_cmp++;
         if (flags_q !== want_f || sticky_v !== m_sticky || taken_cnt !== CNT_W'(m_cnt)) begin
            n_bad++;
            $display("FAIL rnd_state_%0d: got f=%b sv=%b cnt=%0d want f=%b sv=%b cnt=%0d",
                     n, flags_q, sticky_v, taken_cnt, want_f, m_sticky, m_cnt);
         end
      end
      idle_inputs;
   endtask

   initial begin
      idle_inputs;
      test_reset;
      test_err_no_flags;
      test_eq;
      test_signed_unsigned;
      test_backpressure;
      test_bypass;
      test_sticky;
      test_saturation_and_reset;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
